// File: rtl/attack_turn_fsm_if.sv
// attack_turn_fsm_if
//   Bundles the game-control inputs and display-side outputs of attack_turn_fsm.
//   master : game front end / display side (drives start, fire, placement;
//            receives target, attacker flags, results, draw strobe, winner, turn)
//   slave  : the turn sequencer itself
//   Inputs to the sequencer:
//     startFSM             level, high = game running
//     keyFire              single-cycle fire pulse
//     xIn, yIn             attack column / row
//     placeWe              ship-cell write strobe (setup only)
//     placePlayer          0 = player-1 map, 1 = player-2 map
//     placeX, placeY       ship cell column / row
//   Outputs from the sequencer:
//     x, y                 latched target cell
//     isPlayer1/2          attacker of the current draw
//     attackTypePlayer1/2  last shot result per player (1 = hit)
//     attackDisplayControl draw strobe
//     whoWon               00 none, 01 player 1, 10 player 2
//     turn                 0 = player 1 to fire, 1 = player 2 to fire
interface attack_turn_fsm_if;
  logic       startFSM;
  logic       keyFire;
  logic [3:0] xIn;
  logic [3:0] yIn;
  logic       placeWe;
  logic       placePlayer;
  logic [3:0] placeX;
  logic [3:0] placeY;

  logic [3:0] x;
  logic [3:0] y;
  logic       isPlayer1;
  logic       isPlayer2;
  logic       attackTypePlayer1;
  logic       attackTypePlayer2;
  logic       attackDisplayControl;
  logic [1:0] whoWon;
  logic       turn;

  modport master (
    output startFSM, keyFire, xIn, yIn, placeWe, placePlayer, placeX, placeY,
    input  x, y, isPlayer1, isPlayer2, attackTypePlayer1, attackTypePlayer2,
           attackDisplayControl, whoWon, turn
  );

  modport slave (
    input  startFSM, keyFire, xIn, yIn, placeWe, placePlayer, placeX, placeY,
    output x, y, isPlayer1, isPlayer2, attackTypePlayer1, attackTypePlayer2,
           attackDisplayControl, whoWon, turn
  );
endinterface

// File: rtl/attack_turn_fsm.sv
// attack_turn_fsm
//   Game-turn sequencer feeding the display controller. Holds both players'
//   ship maps and shot history, alternates turns, resolves each shot as hit
//   or miss, strobes the display for DRAW_CYCLES cycles per shot and reports
//   the winner.
//   Ports:
//     clk     system clock
//     ResetN  asynchronous active-low reset
//     bus     attack_turn_fsm_if.slave (control inputs, display outputs)
//   Parameters:
//     GRID        board edge in cells (1..16); coordinates >= GRID are invalid
//     SHIP_CELLS  hits on the opponent's map that end the game (1..255)
//     DRAW_CYCLES draw strobe length (fixed to the consumer's 4-bit counter)
//   Build option:
//     ATTACK_EXTRA_TURN_EN  when defined, a non-winning hit keeps the turn
//                           with the attacker; a miss still passes it.
module attack_turn_fsm #(
  parameter int unsigned GRID        = 10,
  parameter int unsigned SHIP_CELLS  = 17,
  parameter int unsigned DRAW_CYCLES = 16
) (
  input  logic              clk,
  input  logic              ResetN,
  attack_turn_fsm_if.slave  bus
);

  localparam int unsigned CELLS     = GRID * GRID;
  localparam int unsigned IDX_W     = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [4:0]  GRID_L    = 5'(GRID);
  localparam logic [7:0]  SHIP_L    = 8'(SHIP_CELLS);
  localparam logic [3:0]  DRAW_LAST = 4'(DRAW_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FIRE,
    CHECK,
    DRAW,
    GAMEOVER
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0][CELLS-1:0]  ship_q, ship_d;
  logic [1:0][CELLS-1:0]  shot_q, shot_d;
  logic [1:0][7:0]        hits_q, hits_d;
  logic [1:0]             atk_q, atk_d;
  logic [3:0]             x_q, x_d;
  logic [3:0]             y_q, y_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   turn_q, turn_d;

  logic [IDX_W-1:0]       fire_idx;
  logic [IDX_W-1:0]       tgt_idx;
  logic [IDX_W-1:0]       place_idx;
  logic                   hit;

  function automatic logic [IDX_W-1:0] cell_idx(input logic [3:0] cx, input logic [3:0] cy);
    int unsigned lin;
    lin = 32'(cy) * GRID + 32'(cx);
    return lin[IDX_W-1:0];
  endfunction

  function automatic logic in_range(input logic [3:0] cx, input logic [3:0] cy);
    return ({1'b0, cx} < GRID_L) && ({1'b0, cy} < GRID_L);
  endfunction

  // State register
  always_ff @(posedge clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      ship_q  <= '0;
      shot_q  <= '0;
      hits_q  <= '0;
      atk_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      turn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ship_q  <= ship_d;
      shot_q  <= shot_d;
      hits_q  <= hits_d;
      atk_q   <= atk_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      turn_q  <= turn_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    ship_d    = ship_q;
    shot_d    = shot_q;
    hits_d    = hits_q;
    atk_d     = atk_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    turn_d    = turn_q;

    fire_idx  = cell_idx(bus.xIn, bus.yIn);
    tgt_idx   = cell_idx(x_q, y_q);
    place_idx = cell_idx(bus.placeX, bus.placeY);
    // turn_q names the attacker from WAIT_FIRE through DRAW, so the
    // opponent's map is the other half.
    hit       = ship_q[~turn_q][tgt_idx];

    if ((state_q != IDLE) && !bus.startFSM) begin
      // Abort: ship layout survives so the same game can be replayed.
      state_d = IDLE;
      shot_d  = '0;
      hits_d  = '0;
      cnt_d   = '0;
      turn_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.placeWe && in_range(bus.placeX, bus.placeY)) begin
            ship_d[bus.placePlayer][place_idx] = 1'b1;
          end
          if (bus.startFSM) begin
            state_d = WAIT_FIRE;
            turn_d  = 1'b0;
          end
        end

        WAIT_FIRE: begin
          if (bus.keyFire && in_range(bus.xIn, bus.yIn) &&
              !shot_q[turn_q][fire_idx]) begin
            x_d     = bus.xIn;
            y_d     = bus.yIn;
            state_d = CHECK;
          end
        end

        CHECK: begin
          shot_d[turn_q][tgt_idx] = 1'b1;
          if (hit && (hits_q[turn_q] != 8'hFF)) begin
            hits_d[turn_q] = hits_q[turn_q] + 8'd1;
          end
          atk_d[turn_q] = hit;
          cnt_d         = '0;
          state_d       = DRAW;
        end

        DRAW: begin
          if (cnt_q == DRAW_LAST) begin
            if (hits_q[turn_q] == SHIP_L) begin
              state_d = GAMEOVER;
            end else begin
              state_d = WAIT_FIRE;
`ifdef ATTACK_EXTRA_TURN_EN
              // The attacker's own result flag holds this shot's outcome.
              if (!atk_q[turn_q]) begin
                turn_d = ~turn_q;
              end
`else
              turn_d = ~turn_q;
`endif
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end

        GAMEOVER: begin
          state_d = GAMEOVER;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs: flags and strobe decode from state, so they are zero the
  // instant reset asserts and can never be high outside DRAW.
  always_comb begin
    bus.x                    = x_q;
    bus.y                    = y_q;
    bus.turn                 = turn_q;
    bus.attackTypePlayer1    = atk_q[0];
    bus.attackTypePlayer2    = atk_q[1];
    bus.attackDisplayControl = (state_q == DRAW);
    bus.isPlayer1            = (state_q == DRAW) && !turn_q;
    bus.isPlayer2            = (state_q == DRAW) && turn_q;
    bus.whoWon               = 2'b00;
    if (state_q == GAMEOVER) begin
      bus.whoWon = turn_q ? 2'b10 : 2'b01;
    end
  end

endmodule
